// File: rtl/matmul_result_drain.sv
// matmul_result_drain: captures the systolic multiplier result and flags on
// finish, then streams the N x M region row-major over a valid/ready port.
// Ports: clk_i, rst_i (async, active-high); finish_i, c_matrix_i, flags_i,
//   n_dim_i, m_dim_i from the multiplier; elem_* stream with elem_ready_i;
//   busy_o, done_o, any_overflow_o, drop_o status back to control.
module matmul_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
  localparam int EW      = 2 * DATA_WIDTH,
  localparam int NE      = MAX_DIM * MAX_DIM
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             finish_i,
  input  logic [NE*EW-1:0] c_matrix_i,
  input  logic [NE-1:0]    flags_i,
  input  logic [2:0]       n_dim_i,
  input  logic [2:0]       m_dim_i,
  output logic [EW-1:0]    elem_data_o,
  output logic [2:0]       elem_row_o,
  output logic [2:0]       elem_col_o,
  output logic             elem_flag_o,
  output logic             elem_last_o,
  output logic             elem_valid_o,
  input  logic             elem_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             any_overflow_o,
  output logic             drop_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] MAX3 = 3'(MAX_DIM);

  logic [1:0]       state_q;
  logic             finish_q;
  logic [NE*EW-1:0] mat_q;
  logic [NE-1:0]    flg_q;
  logic [2:0]       n_q;
  logic [2:0]       m_q;
  logic [2:0]       row_q;
  logic [2:0]       col_q;
  logic             ovf_q;
  logic             drop_q;

  logic       cap_ev;
  logic [2:0] n_eff;
  logic [2:0] m_eff;
  logic       ovf_cap;
  logic       row_end;
  logic       col_end;

  assign cap_ev = finish_i && !finish_q;
  assign n_eff  = (n_dim_i > MAX3) ? MAX3 : n_dim_i;
  assign m_eff  = (m_dim_i > MAX3) ? MAX3 : m_dim_i;

  always_comb begin
    ovf_cap = 1'b0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (r < int'(n_eff) && c < int'(m_eff))
          ovf_cap = ovf_cap | flags_i[r + c*MAX_DIM];
      end
    end
  end

  // Storage is column-major; the stream walks it row-major.
  always_comb begin
    elem_data_o = '0;
    elem_flag_o = 1'b0;
    for (int k = 0; k < NE; k++) begin
      if (k == int'(col_q) * MAX_DIM + int'(row_q)) begin
        elem_data_o = mat_q[k*EW +: EW];
        elem_flag_o = flg_q[k];
      end
    end
  end

  assign row_end = (row_q == n_q - 3'd1);
  assign col_end = (col_q == m_q - 3'd1);

  assign elem_row_o     = row_q;
  assign elem_col_o     = col_q;
  assign elem_valid_o   = (state_q == SEND);
  assign elem_last_o    = elem_valid_o && row_end && col_end;
  assign busy_o         = (state_q == SEND);
  assign done_o         = (state_q == DONE);
  assign any_overflow_o = ovf_q;
  assign drop_o         = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
      mat_q    <= '0;
      flg_q    <= '0;
      n_q      <= '0;
      m_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      finish_q <= finish_i;
      drop_q   <= cap_ev && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (cap_ev) begin
            mat_q <= c_matrix_i;
            flg_q <= flags_i;
            n_q   <= n_eff;
            m_q   <= m_eff;
            row_q <= '0;
            col_q <= '0;
            ovf_q <= ovf_cap;
            if (n_eff == 3'd0 || m_eff == 3'd0)
              state_q <= DONE;
            else
              state_q <= SEND;
          end
        end
        SEND: begin
          if (elem_ready_i) begin
            if (col_end) begin
              col_q <= '0;
              if (row_end) begin
                row_q   <= '0;
                state_q <= DONE;
              end else begin
                row_q <= row_q + 3'd1;
              end
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Result-side companion of the systolic matrix multiplier. Captures the flat product matrix and per-PE overflow flags when the multiplier signals completion. Streams the valid N×M region out one element per handshake, row-major, toward the result scratchpad or bus writer. Reports per-element and aggregate overflow, and a completion pulse back to control.

## Interface
Parameters:
- DATA_WIDTH, 8, operand element width; result elements are 2*DATA_WIDTH.
- BUS_WIDTH, 16, bus width; localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- finish_i  in  1  multiplier completion level; stays high while the result is stable.
- c_matrix_i  in  MAX_DIM*MAX_DIM*2*DATA_WIDTH  signed flat product matrix. Element (r,c) is at bits [(c*MAX_DIM+r)*2*DATA_WIDTH +: 2*DATA_WIDTH].
- flags_i  in  MAX_DIM*MAX_DIM  overflow flags; flag (r,c) is at bit r+c*MAX_DIM.
- n_dim_i  in  3  result rows N.
- m_dim_i  in  3  result columns M.
- elem_data_o  out  2*DATA_WIDTH  current element, signed, passed unmodified.
- elem_row_o  out  3  row index of current element.
- elem_col_o  out  3  column index of current element.
- elem_flag_o  out  1  overflow flag of current element.
- elem_last_o  out  1  high on the final element of the stream.
- elem_valid_o  out  1  element valid.
- elem_ready_i  in  1  consumer accepts; a beat transfers when valid && ready on a clock edge.
- busy_o  out  1  high from capture until the last beat is accepted.
- done_o  out  1  one-cycle pulse after the last beat.
- any_overflow_o  out  1  OR of flags inside the N×M region; valid while done_o is high, held until the next capture.
- drop_o  out  1  one-cycle pulse when a finish rising edge is ignored.

## Operation
- Rising-edge detect on finish_i via a registered copy finish_q. A capture event is finish_i && !finish_q. Holding finish_i high produces exactly one event.
- State machine:
  - IDLE: on a capture event, register c_matrix_i, flags_i, and the effective dims. Set row=col=0.
    - If the effective N or M is 0, go to DONE.
    - Otherwise go to SEND.
  - SEND: on each accepted beat, advance the index:
    - col+1 if col < M-1;
    - else col=0 and row+1.
    - On the beat with row=N-1 and col=M-1, go to DONE.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- Effective dims: values greater than MAX_DIM are clamped to MAX_DIM; 0 means an empty result, producing no beats and a done pulse only.
- Output elements come from the captured registers, never from the live inputs. Input changes after capture have no effect.
- any_overflow_o is computed at capture over flags with r<N and c<M, using the effective dims.
- A capture event while in SEND or DONE is ignored: drop_o pulses and the stream continues unchanged.
- Reset is asynchronous:
  - all outputs go to 0;
  - state goes to IDLE;
  - captured data, indices and finish_q are cleared.
  - Reset mid-stream discards the remainder. After reset, finish_i already high counts as a rising edge.

## Timing
- Capture edge T: elem_valid_o=1 from T+1, presenting (0,0).
- Throughput is one element per cycle with elem_ready_i held high. N×M beats occupy cycles T+1 … T+N*M.
- While valid && !ready, all elem_* outputs hold stable. Valid never drops before acceptance.
- elem_last_o coincides with the final valid beat. elem_valid_o is 0 the cycle after the last acceptance, and done_o is 1 that same cycle.
- busy_o is 1 from T+1 through the last beat's cycle. For an empty result, done_o pulses at T+1 and busy_o stays 0.
- Minimum gap from done_o to the next accepted capture: the next cycle, back in IDLE.

## Test plan
- DATA_WIDTH=8, BUS_WIDTH=16, N=M=2, c_matrix_i=0xFFFC_0002_0003_0001, flags=0, ready=1, finish_i rises at T.
  - Required: beats T+1..T+4 carry data 0x0001, 0x0002, 0x0003, 0xFFFC at (0,0), (0,1), (1,0), (1,1).
  - elem_last_o=1 at T+4; done_o=1 at T+5; any_overflow_o=0.
- Same stimulus with ready pattern 1,0,0,1,1,0,1.
  - Required: the same four values in order; data and indices held during ready=0; last accepted on the 7th cycle.
- N=1, M=2, same matrix.
  - Required: exactly 2 beats, 0x0001 at (0,0) then 0x0002 at (0,1); last on the second beat.
- flags_i=4'b1000.
  - With N=M=2: elem_flag_o=1 only on (1,1); any_overflow_o=1.
  - With N=M=1: one beat, elem_flag_o=0, any_overflow_o=0.
- finish_i held high 10 cycles, then a second rising edge during SEND.
  - Required: one stream only; drop_o pulses once; stream contents unchanged.
  - N=0 case: no valid, done_o only.
- rst_i asserted after 2 accepted beats.
  - Required: all outputs 0 immediately.
  - After release, a new finish rising edge restarts the stream at (0,0) with the newly captured data.
